// File: rtl/wbmem_seq_pkg.sv
// wbmem_seq_pkg
//   Shared definitions for the MNIST weight/bias memory sequencer:
//   - seq_state_t : sequencer states, in the order an inference walks them
//   - L1_LEN      : default [W1|b1] length (784 pixel weights + 1 bias)
//   - L2_LEN      : default [W2|b2] length (32 hidden weights + 1 bias)
//   - ADDR_W      : default width of the ctr1/ctr2 address buses
package wbmem_seq_pkg;

    localparam int L1_LEN = 785;
    localparam int L2_LEN = 33;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        L1       = 3'd1,
        L1_DRAIN = 3'd2,
        ACT1     = 3'd3,
        L2       = 3'd4,
        L2_DRAIN = 3'd5,
        DONE     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/wbmem_seq_if.sv
// wbmem_seq_if
//   Bundle between the control side (start/abort/hold from the picoRV32
//   register block) and the sequencer, plus the strobes and addresses the
//   sequencer hands to the weight memory and the MAC arrays.
//   master : control/datapath side (drives start/abort/hold, observes the rest)
//   slave  : the sequencer itself
interface wbmem_seq_if
    import wbmem_seq_pkg::*;
#(
    parameter int AW = ADDR_W
);
    logic          start;
    logic          abort;
    logic          hold;
    logic          re;
    logic [AW-1:0] ctr1;
    logic [AW-1:0] ctr2;
    logic          acc1_clr;
    logic          w1_valid;
    logic          w1_last;
    logic          act1;
    logic          acc2_clr;
    logic          w2_valid;
    logic          w2_last;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, hold,
        input  re, ctr1, ctr2, acc1_clr, w1_valid, w1_last, act1,
               acc2_clr, w2_valid, w2_last, busy, done
    );

    modport slave (
        input  start, abort, hold,
        output re, ctr1, ctr2, acc1_clr, w1_valid, w1_last, act1,
               acc2_clr, w2_valid, w2_last, busy, done
    );

endinterface

// File: rtl/wbmem_addr_ctr.sv
// wbmem_addr_ctr
//   Issue counter for one weight layer. Walks 0..LEN-1 one step per
//   accepted issue and wraps back to 0 on the issue of the last word, so the
//   counter is already parked at 0 when the layer finishes.
//   Ports:
//     clk, reset : clock and asynchronous active-high reset
//     clr        : synchronous clear to 0 (takes priority over inc)
//     inc        : an address was issued this cycle
//     addr       : current address, zero-extended to ADDR_W
//     at_last    : addr == LEN-1
module wbmem_addr_ctr
    import wbmem_seq_pkg::*;
#(
    parameter int LEN = L1_LEN,
    parameter int AW  = ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic          at_last
);

    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign at_last = (cnt_reg == CW'(LEN - 1));
    assign addr    = AW'(cnt_reg);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = at_last ? '0 : cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/wbmem_seq.sv
// wbmem_seq
//   Sequencer for the MNIST weight/bias memory. Walks [W1|b1] then [W2|b2],
//   driving the memory read enable and the two address counters, and emits
//   valid/last strobes aligned to the one-cycle synchronous memory read so
//   the MAC arrays can accumulate directly off the memory outputs.
//   Ports:
//     clk, reset : clock and asynchronous active-high reset
//     bus        : wbmem_seq_if.slave
//                  in : start (IDLE only), abort (to IDLE, highest priority),
//                       hold (stall issue in L1/L2)
//                  out: re, ctr1, ctr2, acc1_clr, w1_valid, w1_last, act1,
//                       acc2_clr, w2_valid, w2_last, busy, done
module wbmem_seq
#(
    parameter int L1_LEN = wbmem_seq_pkg::L1_LEN,
    parameter int L2_LEN = wbmem_seq_pkg::L2_LEN,
    parameter int ADDR_W = wbmem_seq_pkg::ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    wbmem_seq_if.slave  bus
);

    import wbmem_seq_pkg::*;

    seq_state_t state_reg;
    seq_state_t state_next;

    // Index 0 is layer 1, index 1 is layer 2.
    logic              issue     [2];
    logic              at_last   [2];
    logic [ADDR_W-1:0] addr      [2];
    logic              valid_reg [2];
    logic              last_reg  [2];

    logic re;
    logic clr1_reg;
    logic clr2_reg;
    logic act1;
    logic busy;
    logic done;

    // Combinational so a hold seen this cycle never reaches the memory.
    assign re       = ((state_reg == L1) || (state_reg == L2)) && !bus.hold;
    assign issue[0] = re && (state_reg == L1);
    assign issue[1] = re && (state_reg == L2);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_layer
            localparam int LEN = (gi == 0) ? L1_LEN : L2_LEN;

            wbmem_addr_ctr #(
                .LEN (LEN),
                .AW  (ADDR_W)
            ) u_ctr (
                .clk     (clk),
                .reset   (reset),
                .clr     (bus.abort),
                .inc     (issue[gi]),
                .addr    (addr[gi]),
                .at_last (at_last[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        act1       = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_next = L1;
                end
            end
            L1: begin
                // Only the issue of the bias word leaves the layer, so a
                // hold on the last address keeps us here.
                if (issue[0] && at_last[0]) begin
                    state_next = L1_DRAIN;
                end
            end
            L1_DRAIN: state_next = ACT1;
            ACT1: begin
                act1       = 1'b1;
                state_next = L2;
            end
            L2: begin
                if (issue[1] && at_last[1]) begin
                    state_next = L2_DRAIN;
                end
            end
            L2_DRAIN: state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            clr1_reg  <= 1'b0;
            clr2_reg  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                valid_reg[i] <= 1'b0;
                last_reg[i]  <= 1'b0;
            end
        end else begin
            state_reg <= state_next;
            // Accumulator clears land on the first cycle of each layer,
            // one cycle ahead of that layer's first valid word.
            clr1_reg  <= (state_reg == IDLE) && (state_next == L1);
            clr2_reg  <= (state_reg == ACT1) && (state_next == L2);
            // One-cycle pipeline matching the memory read latency; abort
            // squashes the word still in flight.
            for (int i = 0; i < 2; i++) begin
                valid_reg[i] <= issue[i] && !bus.abort;
                last_reg[i]  <= issue[i] && at_last[i] && !bus.abort;
            end
        end
    end

    assign bus.re       = re;
    assign bus.ctr1     = addr[0];
    assign bus.ctr2     = addr[1];
    assign bus.acc1_clr = clr1_reg;
    assign bus.w1_valid = valid_reg[0];
    assign bus.w1_last  = last_reg[0];
    assign bus.act1     = act1;
    assign bus.acc2_clr = clr2_reg;
    assign bus.w2_valid = valid_reg[1];
    assign bus.w2_last  = last_reg[1];
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule
